// File: rtl/neural_frame_assembler_if.sv
// Bus bundle for neural_frame_assembler.
// ADC side : channel_mask, adc_data_in, adc_channel_in, adc_valid_in (into the assembler)
// Frame side: frame_data_out, frame_present, frame_complete, frame_seq, frame_valid (out),
//             frame_ready (in)
// Status   : drop_count, err_unmasked (out)
// slave  = the assembler, master = the stream source / frame consumer environment.
interface neural_frame_assembler_if #(
    parameter int unsigned NUM_CHANNELS = 16,
    parameter int unsigned DATA_WIDTH   = 16,
    parameter int unsigned CH_ID_WIDTH  = 4,
    parameter int unsigned SEQ_WIDTH    = 8
);
    localparam int unsigned FRAME_W = NUM_CHANNELS * DATA_WIDTH;
    localparam int unsigned DROP_W  = 16;

    logic [NUM_CHANNELS-1:0] channel_mask;
    logic [DATA_WIDTH-1:0]   adc_data_in;
    logic [CH_ID_WIDTH-1:0]  adc_channel_in;
    logic                    adc_valid_in;

    logic [FRAME_W-1:0]      frame_data_out;
    logic [NUM_CHANNELS-1:0] frame_present;
    logic                    frame_complete;
    logic [SEQ_WIDTH-1:0]    frame_seq;
    logic                    frame_valid;
    logic                    frame_ready;

    logic [DROP_W-1:0]       drop_count;
    logic                    err_unmasked;

    modport master (
        output channel_mask, adc_data_in, adc_channel_in, adc_valid_in, frame_ready,
        input  frame_data_out, frame_present, frame_complete, frame_seq, frame_valid,
        input  drop_count, err_unmasked
    );

    modport slave (
        input  channel_mask, adc_data_in, adc_channel_in, adc_valid_in, frame_ready,
        output frame_data_out, frame_present, frame_complete, frame_seq, frame_valid,
        output drop_count, err_unmasked
    );
endinterface

// File: rtl/neural_frame_assembler.sv
// neural_frame_assembler
// Reassembles a serialized (data, channel id, valid) ADC sample stream into parallel
// frames, double-buffers closed frames and presents them behind a valid/ready handshake.
// Incomplete frames (wrap/duplicate channel or idle timeout) are flagged, frames that
// find no free buffer are dropped and counted.
// Ports:
//   i_sys_clk : single clock
//   i_rst     : synchronous active-high reset
//   bus       : neural_frame_assembler_if.slave (ADC stream in, frame handshake out,
//               drop_count / err_unmasked status out)
module neural_frame_assembler #(
    parameter int unsigned NUM_CHANNELS   = 16,
    parameter int unsigned DATA_WIDTH     = 16,
    parameter int unsigned CH_ID_WIDTH    = 4,
    parameter int unsigned SEQ_WIDTH      = 8,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic                    i_sys_clk,
    input  logic                    i_rst,
    neural_frame_assembler_if.slave bus
);

    localparam int unsigned FRAME_W = NUM_CHANNELS * DATA_WIDTH;
    localparam int unsigned DROP_W  = 16;
    localparam int unsigned TO_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int unsigned TO_LAST = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_FILLING  = 2'd1,
        ST_DROPPING = 2'd2
    } state_t;

    // Assembly state
    state_t                  r_state;
    logic [CH_ID_WIDTH-1:0]  r_last_id;
    logic [TO_W-1:0]         r_to_cnt;
    logic [NUM_CHANNELS-1:0] r_frame_mask;
    logic                    r_fill_idx;
    logic [SEQ_WIDTH-1:0]    r_seq;

    // Two frame buffers
    logic [FRAME_W-1:0]      r_buf_data     [2];
    logic [NUM_CHANNELS-1:0] r_buf_present  [2];
    logic                    r_buf_complete [2];
    logic [SEQ_WIDTH-1:0]    r_buf_seq      [2];

    // Order of closed buffers: r_q0 is the head (the one being presented)
    logic                    r_q0;
    logic                    r_q1;
    logic [1:0]              r_q_cnt;

    // Registered outputs
    logic                    r_frame_valid;
    logic [FRAME_W-1:0]      r_frame_data;
    logic [NUM_CHANNELS-1:0] r_frame_present;
    logic                    r_frame_complete;
    logic [SEQ_WIDTH-1:0]    r_frame_seq;
    logic [DROP_W-1:0]       r_drop_count;
    logic                    r_err_unmasked;

    // Sample qualification
    logic [CH_ID_WIDTH-1:0]  w_ch;
    logic [NUM_CHANNELS-1:0] w_mask_chk;
    logic [NUM_CHANNELS-1:0] w_bit;
    logic                    w_in_range;
    logic                    w_accept;
    logic                    w_reject;
    logic                    w_gt_last;
    logic                    w_hs;

    assign w_ch       = bus.adc_channel_in;
    assign w_in_range = ({1'b0, w_ch} < (CH_ID_WIDTH + 1)'(NUM_CHANNELS));
    assign w_mask_chk = (r_state == ST_FILLING) ? r_frame_mask : bus.channel_mask;
    assign w_accept   = bus.adc_valid_in && w_in_range && w_mask_chk[w_ch];
    assign w_reject   = bus.adc_valid_in && !w_accept;
    assign w_bit      = NUM_CHANNELS'(1) << w_ch;
    assign w_gt_last  = (w_ch > r_last_id);
    assign w_hs       = r_frame_valid && bus.frame_ready;

    // Queue contents once this cycle's handshake has released the head
    logic       w_q0_ap;
    logic       w_q1_ap;
    logic [1:0] w_cnt_ap;
    logic       w_queued0;
    logic       w_queued1;
    logic       w_free0;
    logic       w_free1;

    assign w_cnt_ap  = w_hs ? (r_q_cnt - 2'd1) : r_q_cnt;
    assign w_q0_ap   = w_hs ? r_q1 : r_q0;
    assign w_q1_ap   = r_q1;
    assign w_queued0 = ((w_cnt_ap != 2'd0) && (w_q0_ap == 1'b0)) ||
                       ((w_cnt_ap == 2'd2) && (w_q1_ap == 1'b0));
    assign w_queued1 = ((w_cnt_ap != 2'd0) && (w_q0_ap == 1'b1)) ||
                       ((w_cnt_ap == 2'd2) && (w_q1_ap == 1'b1));
    // The buffer being filled is never a candidate: it either continues or gets queued.
    assign w_free0   = !((r_state == ST_FILLING) && (r_fill_idx == 1'b0)) && !w_queued0;
    assign w_free1   = !((r_state == ST_FILLING) && (r_fill_idx == 1'b1)) && !w_queued1;

    // Per-cycle decisions
    state_t                  w_state_nxt;
    logic [CH_ID_WIDTH-1:0]  w_last_nxt;
    logic [TO_W-1:0]         w_to_nxt;
    logic                    w_write_cur;
    logic                    w_close;
    logic                    w_close_cmpl;
    logic                    w_start;
    logic                    w_open;
    logic                    w_new_idx;
    logic                    w_new_close;
    logic                    w_drop_inc;
    logic [SEQ_WIDTH-1:0]    w_new_seq;
    logic [FRAME_W-1:0]      w_cur_data_nxt;
    logic [NUM_CHANNELS-1:0] w_cur_present_nxt;
    logic [FRAME_W-1:0]      w_new_data;
    logic                    w_q0_n;
    logic                    w_q1_n;
    logic [1:0]              w_cnt_n;
    logic [FRAME_W-1:0]      w_head_data;
    logic [NUM_CHANNELS-1:0] w_head_present;
    logic                    w_head_complete;
    logic [SEQ_WIDTH-1:0]    w_head_seq;

    // Next-state, buffer update and queue update decisions
    always_comb begin
        w_state_nxt       = r_state;
        w_last_nxt        = r_last_id;
        w_to_nxt          = r_to_cnt;
        w_write_cur       = 1'b0;
        w_close           = 1'b0;
        w_close_cmpl      = 1'b0;
        w_start           = 1'b0;
        w_open            = 1'b0;
        w_new_idx         = 1'b0;
        w_new_close       = 1'b0;
        w_drop_inc        = 1'b0;
        w_new_seq         = r_seq;
        w_cur_data_nxt    = r_buf_data[r_fill_idx];
        w_cur_present_nxt = r_buf_present[r_fill_idx];
        w_new_data        = '0;
        w_q0_n            = w_q0_ap;
        w_q1_n            = w_q1_ap;
        w_cnt_n           = w_cnt_ap;
        w_head_data       = '0;
        w_head_present    = '0;
        w_head_complete   = 1'b0;
        w_head_seq        = '0;

        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_start = 1'b1;
                end
            end
            ST_FILLING: begin
                if (w_accept) begin
                    w_to_nxt = '0;
                    if (w_gt_last) begin
                        w_write_cur = 1'b1;
                        w_last_nxt  = w_ch;
                        if ((r_buf_present[r_fill_idx] | w_bit) == r_frame_mask) begin
                            w_close      = 1'b1;
                            w_close_cmpl = 1'b1;
                            w_state_nxt  = ST_IDLE;
                        end
                    end else begin
                        // Wrap or duplicate: close incomplete, sample opens the next frame
                        w_close = 1'b1;
                        w_start = 1'b1;
                    end
                end else if (TIMEOUT_CYCLES != 0) begin
                    if (r_to_cnt == TO_W'(TO_LAST)) begin
                        w_close     = 1'b1;
                        w_state_nxt = ST_IDLE;
                        w_to_nxt    = '0;
                    end else begin
                        w_to_nxt = r_to_cnt + TO_W'(1);
                    end
                end
            end
            ST_DROPPING: begin
                if (w_accept) begin
                    w_to_nxt = '0;
                    if (w_gt_last) begin
                        w_last_nxt = w_ch;
                    end else begin
                        w_start = 1'b1;
                    end
                end else if (TIMEOUT_CYCLES != 0) begin
                    if (r_to_cnt == TO_W'(TO_LAST)) begin
                        w_state_nxt = ST_IDLE;
                        w_to_nxt    = '0;
                    end else begin
                        w_to_nxt = r_to_cnt + TO_W'(1);
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        // Opening a new frame: claim a free buffer or drop the whole frame
        if (w_start) begin
            w_last_nxt = w_ch;
            w_to_nxt   = '0;
            if (w_free0 || w_free1) begin
                w_open    = 1'b1;
                w_new_idx = w_free0 ? 1'b0 : 1'b1;
                w_new_data[32'(w_ch) * DATA_WIDTH +: DATA_WIDTH] = bus.adc_data_in;
                // A single-channel mask completes on its first sample
                if (w_bit == bus.channel_mask) begin
                    w_new_close = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_FILLING;
                end
            end else begin
                w_drop_inc  = 1'b1;
                w_state_nxt = ST_DROPPING;
            end
        end

        if (w_write_cur) begin
            w_cur_data_nxt[32'(w_ch) * DATA_WIDTH +: DATA_WIDTH] = bus.adc_data_in;
            w_cur_present_nxt = r_buf_present[r_fill_idx] | w_bit;
        end

        w_new_seq = r_seq + SEQ_WIDTH'(w_close);

        // Push closed buffers behind whatever survives the pop, oldest first
        if (w_close) begin
            if (w_cnt_n == 2'd0) begin
                w_q0_n = r_fill_idx;
            end else begin
                w_q1_n = r_fill_idx;
            end
            w_cnt_n = w_cnt_n + 2'd1;
        end
        if (w_new_close) begin
            if (w_cnt_n == 2'd0) begin
                w_q0_n = w_new_idx;
            end else begin
                w_q1_n = w_new_idx;
            end
            w_cnt_n = w_cnt_n + 2'd1;
        end

        // Head contents as they will be after this edge (bypass buffers written now)
        if (w_close && (w_q0_n == r_fill_idx)) begin
            w_head_data     = w_cur_data_nxt;
            w_head_present  = w_cur_present_nxt;
            w_head_complete = w_close_cmpl;
            w_head_seq      = r_seq;
        end else if (w_new_close && (w_q0_n == w_new_idx)) begin
            w_head_data     = w_new_data;
            w_head_present  = w_bit;
            w_head_complete = 1'b1;
            w_head_seq      = w_new_seq;
        end else begin
            w_head_data     = r_buf_data[w_q0_n];
            w_head_present  = r_buf_present[w_q0_n];
            w_head_complete = r_buf_complete[w_q0_n];
            w_head_seq      = r_buf_seq[w_q0_n];
        end
    end

    // State, buffers, queue and output registers
    always_ff @(posedge i_sys_clk) begin
        if (i_rst) begin
            r_state          <= ST_IDLE;
            r_last_id        <= '0;
            r_to_cnt         <= '0;
            r_frame_mask     <= '0;
            r_fill_idx       <= 1'b0;
            r_seq            <= '0;
            for (int b = 0; b < 2; b++) begin
                r_buf_data[b]     <= '0;
                r_buf_present[b]  <= '0;
                r_buf_complete[b] <= 1'b0;
                r_buf_seq[b]      <= '0;
            end
            r_q0             <= 1'b0;
            r_q1             <= 1'b0;
            r_q_cnt          <= 2'd0;
            r_frame_valid    <= 1'b0;
            r_frame_data     <= '0;
            r_frame_present  <= '0;
            r_frame_complete <= 1'b0;
            r_frame_seq      <= '0;
            r_drop_count     <= '0;
            r_err_unmasked   <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_last_id      <= w_last_nxt;
            r_to_cnt       <= w_to_nxt;
            r_seq          <= r_seq + SEQ_WIDTH'(w_close) + SEQ_WIDTH'(w_new_close);
            r_q0           <= w_q0_n;
            r_q1           <= w_q1_n;
            r_q_cnt        <= w_cnt_n;
            r_err_unmasked <= w_reject;

            if (w_write_cur || w_close) begin
                r_buf_data[r_fill_idx]    <= w_cur_data_nxt;
                r_buf_present[r_fill_idx] <= w_cur_present_nxt;
            end
            if (w_close) begin
                r_buf_complete[r_fill_idx] <= w_close_cmpl;
                r_buf_seq[r_fill_idx]      <= r_seq;
            end

            if (w_open) begin
                r_fill_idx                <= w_new_idx;
                r_frame_mask              <= bus.channel_mask;
                r_buf_data[w_new_idx]     <= w_new_data;
                r_buf_present[w_new_idx]  <= w_bit;
                r_buf_complete[w_new_idx] <= w_new_close;
                r_buf_seq[w_new_idx]      <= w_new_seq;
            end

            if (w_drop_inc && (r_drop_count != {DROP_W{1'b1}})) begin
                r_drop_count <= r_drop_count + DROP_W'(1);
            end

            // Presented frame is frozen until the handshake retires it
            if (w_cnt_n != 2'd0) begin
                if (!r_frame_valid || w_hs) begin
                    r_frame_valid    <= 1'b1;
                    r_frame_data     <= w_head_data;
                    r_frame_present  <= w_head_present;
                    r_frame_complete <= w_head_complete;
                    r_frame_seq      <= w_head_seq;
                end
            end else begin
                r_frame_valid <= 1'b0;
            end
        end
    end

    assign bus.frame_valid    = r_frame_valid;
    assign bus.frame_data_out = r_frame_data;
    assign bus.frame_present  = r_frame_present;
    assign bus.frame_complete = r_frame_complete;
    assign bus.frame_seq      = r_frame_seq;
    assign bus.drop_count     = r_drop_count;
    assign bus.err_unmasked   = r_err_unmasked;

endmodule

// File: doc/neural_frame_assembler.md
Name: neural_frame_assembler

Overview:
- Receive end of the serialized ADC sample stream (data, channel ID, valid) produced by the channel-sweep aggregator on sys_clk.
- Reassembles per-sweep samples into full parallel frames.
- Double-buffers completed frames behind a valid/ready handshake toward the downstream frame consumer (DMA/packetizer).
- Flags incomplete frames and counts frames dropped due to backpressure.

Parameters:
- NUM_CHANNELS, 16, channels per frame
- DATA_WIDTH, 16, sample width
- CH_ID_WIDTH, 4, channel ID width (2**CH_ID_WIDTH >= NUM_CHANNELS)
- SEQ_WIDTH, 8, frame sequence counter width
- TIMEOUT_CYCLES, 64, idle cycles mid-frame before forced close; 0 disables

Ports:
- sys_clk  in  1  single clock
- rst  in  1  synchronous, active-high reset
- channel_mask  in  NUM_CHANNELS  enabled channels; must match the aggregator's mask
- adc_data_in  in  DATA_WIDTH  sample
- adc_channel_in  in  CH_ID_WIDTH  sample channel ID
- adc_valid_in  in  1  sample qualifier; no backpressure, every valid cycle is consumed
- frame_data_out  out  NUM_CHANNELS*DATA_WIDTH  frame, channel i at bits [i*DATA_WIDTH +: DATA_WIDTH]
- frame_present  out  NUM_CHANNELS  bit i set if channel i was received
- frame_complete  out  1  frame_present == frame mask
- frame_seq  out  SEQ_WIDTH  sequence number of the presented frame
- frame_valid  out  1  frame available
- frame_ready  in  1  consumer accepts when frame_valid && frame_ready
- drop_count  out  16  saturating count of dropped frames
- err_unmasked  out  1  one-cycle pulse: sample for a masked-off or out-of-range channel was discarded

Behaviour:
- Reset, synchronous, priority over everything: both buffers free and zeroed, state IDLE, last_id=0, timeout counter=0, frame_valid=0, frame_data_out=0, frame_present=0, frame_complete=0, frame_seq=0, drop_count=0, err_unmasked=0. Reset mid-frame discards all partial and buffered frames.
- Sample filter: a valid sample with channel >= NUM_CHANNELS, or with its mask bit clear, is discarded. err_unmasked pulses on the next cycle and no state changes. Frame-mask bits are checked from the latched frame mask while FILLING and from live channel_mask in IDLE/DROPPING.
- Storage: two frame buffers (data, present, complete, seq) plus a 2-deep FIFO order of filled buffers.
- A buffer is free if it is neither filling nor queued. A buffer released by a handshake in the same cycle counts as free.
- State IDLE: on an accepted sample:
  - If a buffer is free: clear its data and present bits, latch channel_mask as the frame mask, write the sample, set last_id, go to FILLING.
  - If no buffer is free: go to DROPPING and increment drop_count (saturating at 0xFFFF).
- State FILLING: an accepted sample with channel > last_id is written, sets its present bit, and updates last_id.
- Frame boundary: a sample with channel <= last_id (wrap or duplicate) closes the current frame as incomplete. The same sample then starts a new frame with the IDLE rules, in the same cycle.
- Normal close: when present (including this cycle's write) == frame mask, close with complete=1 and go to IDLE.
- Timeout: in FILLING, count cycles without an accepted sample. Reaching TIMEOUT_CYCLES closes the frame as incomplete and goes to IDLE. The counter resets on every accepted sample.
- State DROPPING: samples are discarded while channel > last_id, with last_id updated. A boundary sample or a timeout ends the drop, and a boundary sample is handled per IDLE rules. drop_count counts once per dropped frame.
- Close action: the buffer is tagged with the seq counter and pushed to the output FIFO. seq increments modulo 2**SEQ_WIDTH. Dropped frames do not consume seq.
- Output: head of the FIFO is presented registered. frame_valid rises the cycle after the close cycle.
- While frame_valid=1, all frame_* outputs are held stable until handshake.
- After a handshake, the next queued frame, if any, is presented on the following cycle, so frame_valid stays high. Otherwise frame_valid=0.
- Missing channels read 0 in frame_data_out.

Test Plan:
- Mask 0xFFFF; sweep ch0..15, data 0x1000+ch, on consecutive cycles; frame_ready=1 -> frame_valid one cycle after ch15. All 16 words 0x1000+i, present=0xFFFF, complete=1, seq=0.
- Mask 0x00A5; samples ch0,2,5,7 -> frame closes after ch7. present=0x00A5, complete=1, words 1,3,4,6 read 0.
- Mask 0xFFFF; ch0..5 then ch0..15 -> first frame present=0x003F, complete=0, seq=0. Second frame complete=1, seq=1.
- frame_ready=0; three full sweeps -> two frames buffered, third dropped, drop_count=1. Raise ready -> seq 0 and 1 delivered back-to-back with frame_valid continuous.
- ch0..3 then 64 idle cycles -> incomplete frame with present=0x000F closed at the timeout. Unmasked ch sample (mask 0x7FFF, ch15) -> err_unmasked pulse, no frame change.
- Assert rst while FILLING with one frame queued -> next cycle frame_valid=0, drop_count=0. Fresh sweep yields seq=0.
